dev_arbiter: RTL and testbench
==============================

DEV_ARBITER -- requirements
Module: dev_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 16 (legal 2..255): the maximum number of BUSY cycles before a transaction is aborted.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 m0_req  input  1  CPU request; held until one cycle after m0_ack.
REQ-006 m0_addr  input  30  CPU word address [31:2].
REQ-007 m0_wd  input  32  CPU write data.
REQ-008 m0_we  input  1  CPU write enable (1 = write, 0 = read).
REQ-009 m0_rd  output  32  read data returned to the CPU.
REQ-010 m0_ack  output  1  one-cycle completion pulse to the CPU.
REQ-011 m0_err  output  1  timeout flag, valid with m0_ack.
REQ-012 m1_req, m1_addr, m1_wd, m1_we, m1_rd, m1_ack, m1_err SHALL be identical in direction and width to the m0_* ports and serve the second master (DMA).
REQ-013 bus_addr  output  30  word address driven to the bridge.
REQ-014 bus_wd  output  32  write data to the bridge.
REQ-015 bus_wen  output  1  write strobe to the bridge.
REQ-016 bus_rd  input  32  read data from the bridge.
REQ-017 bus_ready  input  1  device completion for the current access.
REQ-018 grant  output  2  one-hot owner: bit0 = m0, bit1 = m1; 00 when no owner.

Function
REQ-019 The block SHALL implement four states, IDLE, BUSY0, BUSY1 and DONE, in a registered FSM.
REQ-020 In IDLE with exactly one req high, the FSM SHALL enter BUSY of that master at the next edge.
REQ-021 In IDLE with both reqs high, the FSM SHALL grant the master selected by the round-robin pointer.
REQ-022 The pointer SHALL reset to m0 and SHALL switch to the other master at every BUSY->DONE transition, whether completed or timed out.
REQ-023 In IDLE with no request, the FSM SHALL stay in IDLE and leave the pointer unchanged.
REQ-024 In BUSYn, bus_addr, bus_wd and bus_wen SHALL combinationally follow mn_addr, mn_wd and mn_we.
REQ-025 In IDLE and DONE, bus_addr, bus_wd and bus_wen SHALL be 0.
REQ-026 grant SHALL be 01 in BUSY0, 10 in BUSY1, and 00 in IDLE and DONE.
REQ-027 In BUSYn, a bus_ready sampled high SHALL move the FSM to DONE and register bus_rd into mn_rd with mn_err=0.
REQ-028 In BUSYn, an 8-bit wait counter (cleared on BUSY entry) SHALL increment every cycle without bus_ready.
REQ-029 When the wait counter equals TIMEOUT-1 without bus_ready, the FSM SHALL move to DONE with mn_rd=0 and mn_err=1.
REQ-030 bus_ready in the same cycle as the timeout condition SHALL win: normal completion, err=0.
REQ-031 In DONE, mn_ack SHALL be 1 for exactly that one cycle; DONE SHALL always return to IDLE at the next edge.
REQ-032 mn_rd and mn_err SHALL hold their values until that master's next completion.
REQ-033 Minimum latency SHALL be 3 cycles from req sampled to ack: IDLE edge, then ready sampled in the first BUSY cycle, then ack in DONE.
REQ-034 The arbiter SHALL NOT re-grant a master in the IDLE cycle that follows DONE if that master has deasserted req per the protocol.
REQ-035 A req dropped during BUSY is a protocol violation; the transaction SHALL still complete normally.
REQ-036 bus_ready in IDLE or DONE SHALL be ignored.
REQ-037 bus_wen SHALL never be asserted for more than one transaction without an intervening IDLE cycle.

Reset
REQ-038 reset high SHALL force asynchronously: state IDLE, pointer m0, wait counter 0, grant 00, m0_ack, m1_ack, m0_err and m1_err all 0, m0_rd and m1_rd 0x00000000.
REQ-039 bus_* outputs SHALL follow the IDLE rule while reset is high.
REQ-040 Reset during BUSY SHALL abort the access with no ack; the first post-reset arbitration SHALL favour m0.

Verification
REQ-041 m0 read of 0x00007F04, bus_ready high on the first BUSY cycle, bus_rd=0x12345678 -> m0_ack one cycle, m0_rd=0x12345678, m0_err=0, total 3 cycles.
REQ-042 m0 and m1 request simultaneously from reset, each access acked -> grant order m0, m1, m0, m1 over four transactions.
REQ-043 m1 write of addr 0x00007F00, wd=0x9 -> bus_wen=1 and bus_wd=0x9 only in BUSY1; bus_wen=0 in DONE.
REQ-044 TIMEOUT=4, bus_ready held low -> DONE after 4 BUSY cycles, m0_ack=1, m0_err=1, m0_rd=0; the next arbitration favours m1.
REQ-045 bus_ready rises on exactly the timeout cycle -> err=0 and data latched.
REQ-046 reset asserted mid-BUSY1 -> grant=00 immediately, no m1_ack; after release with both reqs high, m0 is granted.

Source files
------------

// File: rtl/dev_arbiter.sv
// dev_arbiter: two-master (CPU = m0, DMA = m1) arbiter in front of a single
// bridge port. One transaction at a time: IDLE -> BUSYn -> DONE -> IDLE.
// Contested requests are resolved by a round-robin pointer that flips on
// every completion. A BUSY phase ends on bus_ready or after TIMEOUT cycles.
module dev_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    // master 0 (CPU)
    input  logic        m0_req,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic        m0_we,
    output logic [31:0] m0_rd,
    output logic        m0_ack,
    output logic        m0_err,
    // master 1 (DMA)
    input  logic        m1_req,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic        m1_we,
    output logic [31:0] m1_rd,
    output logic        m1_ack,
    output logic        m1_err,
    // bridge side
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wd,
    output logic        bus_wen,
    input  logic [31:0] bus_rd,
    input  logic        bus_ready,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Last value of the wait counter before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       ptr;      // 0: m0 wins a tie, 1: m1 wins a tie
    logic [7:0] wcnt;     // BUSY cycles elapsed without bus_ready

    logic       finish;   // BUSY phase ends at this edge
    logic [31:0] rd_next;
    logic       err_next;

    // End-of-access decode; bus_ready takes priority over the timeout.
    always_comb begin
        finish   = 1'b0;
        rd_next  = 32'h0;
        err_next = 1'b0;
        if (state == BUSY0 || state == BUSY1) begin
            if (bus_ready) begin
                finish  = 1'b1;
                rd_next = bus_rd;
            end else if (wcnt == WAIT_LAST) begin
                finish   = 1'b1;
                err_next = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered per-master completion results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            wcnt   <= 8'h0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            m0_rd  <= 32'h0;
            m1_rd  <= 32'h0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    wcnt <= 8'h0;
                    if (m0_req && (!m1_req || !ptr))
                        state <= BUSY0;
                    else if (m1_req)
                        state <= BUSY1;
                end
                BUSY0, BUSY1: begin
                    if (finish) begin
                        state <= DONE;
                        ptr   <= ~ptr;
                        wcnt  <= 8'h0;
                        if (state == BUSY0) begin
                            m0_ack <= 1'b1;
                            m0_rd  <= rd_next;
                            m0_err <= err_next;
                        end else begin
                            m1_ack <= 1'b1;
                            m1_rd  <= rd_next;
                            m1_err <= err_next;
                        end
                    end else begin
                        wcnt <= wcnt + 8'h1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus mux and grant decode; everything is quiet outside BUSY.
    always_comb begin
        bus_addr = 30'h0;
        bus_wd   = 32'h0;
        bus_wen  = 1'b0;
        grant    = 2'b00;
        case (state)
            BUSY0: begin
                bus_addr = m0_addr;
                bus_wd   = m0_wd;
                bus_wen  = m0_we;
                grant    = 2'b01;
            end
            BUSY1: begin
                bus_addr = m1_addr;
                bus_wd   = m1_wd;
                bus_wen  = m1_we;
                grant    = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dev_arbiter.sv
// tb_dev_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a transaction-level reference model of the arbiter.
module tb_dev_arbiter;

    localparam int T = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0]        req = '0;
    logic [1:0][29:0]  addr = '0;
    logic [1:0][31:0]  wd = '0;
    logic [1:0]        we = '0;
    logic [31:0]       bus_rd = '0;
    logic              ready = 1'b0;

    logic [31:0] m0_rd, m1_rd;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [29:0] bus_addr;
    logic [31:0] bus_wd;
    logic        bus_wen;
    logic [1:0]  grant;

    int n_vec = 0;
    int n_err = 0;

    dev_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_addr(addr[0]), .m0_wd(wd[0]), .m0_we(we[0]),
        .m0_rd(m0_rd), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(req[1]), .m1_addr(addr[1]), .m1_wd(wd[1]), .m1_we(we[1]),
        .m1_rd(m1_rd), .m1_ack(m1_ack), .m1_err(m1_err),
        .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_wen(bus_wen),
        .bus_rd(bus_rd), .bus_ready(ready), .grant(grant)
    );

    initial forever #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 an access in flight for 'own', 2 completion cycle.
    int               phase, own, elapsed, favour;
    logic [1:0][31:0] e_rd;
    logic [1:0]       e_err, e_ack;

    task automatic mdl_reset();
        phase = 0; own = 0; elapsed = 0; favour = 0;
        e_rd = '0; e_err = '0; e_ack = '0;
    endtask

    // Advance one clock using the inputs present at the edge.
    task automatic mdl_step();
        e_ack = '0;
        case (phase)
            0: if (req != 2'b00) begin
                   own     = (req == 2'b11) ? favour : (req[1] ? 1 : 0);
                   phase   = 1;
                   elapsed = 1;
               end
            1: if (ready || elapsed == T) begin
                   e_rd[own]  = ready ? bus_rd : 32'h0;
                   e_err[own] = !ready;
                   e_ack[own] = 1'b1;
                   favour     = 1 - favour;
                   phase      = 2;
               end else begin
                   elapsed++;
               end
            default: phase = 0;
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all();
        logic [1:0] g;
        g = (phase == 1) ? (own == 1 ? 2'b10 : 2'b01) : 2'b00;
        chk("grant", 32'(grant), 32'(g));
        chk("bus_addr", 32'(bus_addr), (phase == 1) ? 32'(addr[own]) : 32'h0);
        chk("bus_wd", bus_wd, (phase == 1) ? wd[own] : 32'h0);
        chk("bus_wen", 32'(bus_wen), (phase == 1) ? 32'(we[own]) : 32'h0);
        chk("m0_ack", 32'(m0_ack), 32'(e_ack[0]));
        chk("m1_ack", 32'(m1_ack), 32'(e_ack[1]));
        chk("m0_err", 32'(m0_err), 32'(e_err[0]));
        chk("m1_err", 32'(m1_err), 32'(e_err[1]));
        chk("m0_rd", m0_rd, e_rd[0]);
        chk("m1_rd", m1_rd, e_rd[1]);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) mdl_step();
        @(negedge clk);
        chk_all();
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        mdl_reset();
        #1 chk_all();
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    // Random master behaviour: hold req until the cycle after ack.
    task automatic drive_random();
        for (int i = 0; i < 2; i++) begin
            if (req[i] && e_ack[i]) begin
                req[i] = 1'b0;
            end else if (req[i]) begin
                if ($urandom % 64 == 0) req[i] = 1'b0;
            end else if ($urandom % 3 == 0) begin
                req[i]  = 1'b1;
                addr[i] = 30'($urandom);
                wd[i]   = $urandom;
                we[i]   = 1'($urandom);
            end
        end
        ready  = ($urandom % 3 == 0);
        bus_rd = $urandom;
    endtask

    logic [7:0] gseq;

    initial begin
        mdl_reset();
        #2;
        apply_reset(2);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_m0_rd", m0_rd, 32'h0);

        // m0 read, ready on first BUSY cycle: ack in third cycle.
        addr[0] = 30'h7F04; we[0] = 1'b0; wd[0] = 32'h0; req = 2'b01;
        ready = 1'b1; bus_rd = 32'h12345678;
        tick();
        chk("t41_grant", 32'(grant), 32'h1);
        chk("t41_addr", 32'(bus_addr), 32'h7F04);
        tick();
        chk("t41_ack", 32'(m0_ack), 32'h1);
        chk("t41_rd", m0_rd, 32'h12345678);
        chk("t41_err", 32'(m0_err), 32'h0);
        req = 2'b00; ready = 1'b0;
        tick();
        chk("t41_ack_once", 32'(m0_ack), 32'h0);

        // m1 write: wen only while BUSY1.
        addr[1] = 30'h7F00; wd[1] = 32'h9; we[1] = 1'b1; req = 2'b10; ready = 1'b1;
        tick();
        chk("t43_grant", 32'(grant), 32'h2);
        chk("t43_wen", 32'(bus_wen), 32'h1);
        chk("t43_wd", bus_wd, 32'h9);
        tick();
        chk("t43_wen_done", 32'(bus_wen), 32'h0);
        chk("t43_ack", 32'(m1_ack), 32'h1);
        req = 2'b00; ready = 1'b0;
        tick();

        // Contested requests from reset alternate m0, m1, m0, m1.
        apply_reset(2);
        we = 2'b00; req = 2'b11; ready = 1'b1; gseq = 8'h0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (grant != 2'b00) gseq = {gseq[5:0], grant};
        end
        chk("t42_order", 32'(gseq), 32'h66);
        req = 2'b00; ready = 1'b0;
        tick();

        // Timeout after T BUSY cycles, then pointer favours m1.
        apply_reset(2);
        addr[0] = 30'h100; we[0] = 1'b0; req = 2'b01; ready = 1'b0; bus_rd = 32'hDEADBEEF;
        repeat (T) tick();
        chk("t44_still_busy", 32'(grant), 32'h1);
        tick();
        chk("t44_ack", 32'(m0_ack), 32'h1);
        chk("t44_err", 32'(m0_err), 32'h1);
        chk("t44_rd", m0_rd, 32'h0);
        req = 2'b11;
        tick();
        tick();
        chk("t44_favour_m1", 32'(grant), 32'h2);
        ready = 1'b1;
        tick();
        req = 2'b00; ready = 1'b0;
        tick();

        // bus_ready on exactly the timeout cycle wins.
        addr[0] = 30'h200; req = 2'b01; ready = 1'b0;
        repeat (T) tick();
        ready = 1'b1; bus_rd = 32'hCAFEF00D;
        tick();
        chk("t45_ack", 32'(m0_ack), 32'h1);
        chk("t45_err", 32'(m0_err), 32'h0);
        chk("t45_rd", m0_rd, 32'hCAFEF00D);
        req = 2'b00; ready = 1'b0;
        tick();

        // Reset in the middle of BUSY1 aborts without ack.
        addr[1] = 30'h300; we[1] = 1'b0; req = 2'b10;
        tick();
        tick();
        chk("t46_busy1", 32'(grant), 32'h2);
        reset = 1'b1;
        mdl_reset();
        #1;
        chk("t46_grant_async", 32'(grant), 32'h0);
        chk("t46_no_ack", 32'(m1_ack), 32'h0);
        req = 2'b11;
        tick();
        reset = 1'b0;
        tick();
        chk("t46_m0_first", 32'(grant), 32'h1);
        ready = 1'b1;
        tick();
        req = 2'b00; ready = 1'b0;
        tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom % 500 == 0) apply_reset(1);
            drive_random();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
